// File: rtl/streaming_dwc_up.sv
// streaming_dwc_up: packs R narrow input beats into one wide output word.
// Beats are packed LSB-first; out data/valid are registered.
module streaming_dwc_up #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
    input  logic                 in0_V_V_TVALID,
    output logic                 in0_V_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
    output logic                 out_V_V_TVALID,
    input  logic                 out_V_V_TREADY,
    output logic [7:0]           fill
);

    localparam int R  = OUT_WIDTH / IN_WIDTH;
    localparam int CW = (R > 2) ? $clog2(R) : 1;
    localparam logic [CW-1:0] LAST = CW'(R - 1);

    if ((OUT_WIDTH % IN_WIDTH) != 0 || (OUT_WIDTH / IN_WIDTH) < 2) begin : g_bad_ratio
        $error("OUT_WIDTH must be an integer multiple (>=2) of IN_WIDTH");
    end

    logic [R-2:0][IN_WIDTH-1:0] slots;
    logic [CW-1:0]              cnt;
    logic [OUT_WIDTH-1:0]       out_data;
    logic                       out_valid;
    logic                       accept;
    logic                       consume;
    logic                       last_beat;

    // The final beat of a word may only enter once the output register can take it.
    always_comb begin
        in0_V_V_TREADY = !ap_rst && (cnt != LAST || !out_valid || out_V_V_TREADY);
        accept         = in0_V_V_TVALID && in0_V_V_TREADY;
        consume        = out_valid && out_V_V_TREADY;
        last_beat      = accept && (cnt == LAST);
    end

    // Zero-extend the beat counter onto the fill port.
    always_comb begin
        fill         = '0;
        fill[CW-1:0] = cnt;
    end

    // Partial beats land in the slot addressed by the current count.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            slots <= '0;
        end else if (accept && !last_beat) begin
            for (int i = 0; i < R - 1; i++) begin
                if (cnt == CW'(i)) begin
                    slots[i] <= in0_V_V_TDATA;
                end
            end
        end
    end

    // Beat counter and output register; a reload wins over a consume.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (last_beat) begin
            cnt       <= '0;
            out_data  <= {in0_V_V_TDATA, slots};
            out_valid <= 1'b1;
        end else begin
            if (consume) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign out_V_V_TDATA  = out_data;
    assign out_V_V_TVALID = out_valid;

endmodule
